// File: rtl/mem_bank.sv
// Byte-writable single-port-per-direction memory bank with optional post-reset
// zero fill, configurable read-during-write behaviour and optional output register.
module mem_bank #(
  parameter  int XLEN       = 32,
  parameter  int SIZE       = 256,
  parameter  int RDW_MODE   = 0,
  parameter  int OUT_REG    = 0,
  parameter  int INIT_CLEAR = 1,
  localparam int ADDR       = $clog2(SIZE),
  localparam int BE         = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            write,
  input  logic [ADDR-1:0] write_addr,
  input  logic [XLEN-1:0] write_data,
  input  logic [BE-1:0]   write_be,
  input  logic            read,
  input  logic [ADDR-1:0] read_addr,
  output logic [XLEN-1:0] read_data,
  output logic            read_valid,
  output logic            busy
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR:0]   SIZE_X    = (ADDR+1)'(SIZE);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(SIZE - 1);

  state_t          state_q, state_d;
  logic [ADDR-1:0] clr_cnt;
  logic [XLEN-1:0] mem [SIZE];

  logic            wr_ok, rd_acc, rd_in_range;
  logic [XLEN-1:0] rd_word;
  logic            v1;
  logic [XLEN-1:0] d1;

  assign wr_ok       = write && !busy && ({1'b0, write_addr} < SIZE_X);
  assign rd_acc      = read && !busy;
  assign rd_in_range = {1'b0, read_addr} < SIZE_X;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy    = (state_q == CLEAR);
    if (state_q == CLEAR && clr_cnt == LAST_ADDR) state_d = READY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (INIT_CLEAR != 0) ? CLEAR : READY;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_cnt <= clr_cnt + ADDR'(1);
    end
  end

  // NOTE: the array has no reset; zeroing is done word by word by the CLEAR walk.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < BE; b++)
        if (write_be[b]) mem[write_addr][8*b +: 8] <= write_data[8*b +: 8];
    end
  end

  // Bypass merges only the enabled bytes of the concurrent write into the old word.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[read_addr];
      if (RDW_MODE != 0 && wr_ok && write_addr == read_addr) begin
        for (int b = 0; b < BE; b++)
          if (write_be[b]) rd_word[8*b +: 8] = write_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) d1 <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic            v2;
      logic [XLEN-1:0] d2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end
      assign read_valid = v2;
      assign read_data  = d2;
    end else begin : g_no_out_reg
      assign read_valid = v1;
      assign read_data  = d1;
    end
  endgenerate

endmodule

// File: doc/mem_bank.md
MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter SIZE, default 256: number of words; need not be a power of two.
REQ-003 SHALL have parameter RDW_MODE, default 0: same-address read-during-write behaviour; 0 = old data, 1 = new data (bypass).
REQ-004 SHALL have parameter OUT_REG, default 0: 1 adds one output register stage.
REQ-005 SHALL have parameter INIT_CLEAR, default 1: 1 zeroes the whole array after reset.
REQ-006 SHALL derive localparam ADDR = $clog2(SIZE) and BE = XLEN/8.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  rising-edge clock for all state.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 write  input  1  write request.
REQ-011 write_addr  input  ADDR  write word address.
REQ-012 write_data  input  XLEN  write data.
REQ-013 write_be  input  BE  byte enables; bit i covers write_data[8i+7:8i].
REQ-014 read  input  1  read request.
REQ-015 read_addr  input  ADDR  read word address.
REQ-016 read_data  output  XLEN  read result.
REQ-017 read_valid  output  1  one-cycle pulse; read_data holds the result of a read.
REQ-018 busy  output  1  high while clearing; requests are ignored while high.

Function
REQ-019 SHALL update each byte whose write_be bit is set on the clk edge where write=1 and busy=0; other bytes unchanged.
REQ-020 SHALL make a write with write_be=0 a no-op.
REQ-021 SHALL ignore writes with write_addr >= SIZE.
REQ-022 SHALL present read data with read_valid=1 exactly 1+OUT_REG cycles after the edge sampling read=1 with busy=0.
REQ-023 SHALL accept one read per cycle, fully pipelined.
REQ-024 SHALL return 0 for reads with read_addr >= SIZE, still with read_valid pulsed.
REQ-025 SHALL hold read_data at its last value when no result is presented (read_valid=0).
REQ-026 Same-address read and write in one cycle, RDW_MODE=0: SHALL return pre-write contents.
REQ-027 Same-address read and write in one cycle, RDW_MODE=1: SHALL return old word with enabled bytes replaced by write_data.
REQ-028 SHALL use FSM states CLEAR and READY.
REQ-029 CLEAR: SHALL write 0 to address counter value, one word per cycle, counter 0 to SIZE-1; busy=1.
REQ-030 SHALL move CLEAR to READY on the cycle after writing address SIZE-1; busy falls on the same edge.
REQ-031 READY SHALL be terminal until the next reset.
REQ-032 With INIT_CLEAR=0, SHALL start in READY with busy=0; array contents undefined.
REQ-033 SHALL ignore read and write requests while busy=1; no read_valid results.
REQ-034 SHALL still deliver reads accepted before busy rose (pipeline drains only after reset); not applicable otherwise.

Reset
REQ-035 rst_n low SHALL immediately force read_data=0, read_valid=0, clear counter=0 and the output-register pipeline empty.
REQ-036 rst_n low SHALL set state CLEAR with busy=1 if INIT_CLEAR=1, else READY with busy=0.
REQ-037 Reset SHALL NOT directly reset array contents; only the CLEAR sequence zeroes them.
REQ-038 Reset asserted mid-CLEAR SHALL restart clearing from address 0 after release.
REQ-039 Reset with reads in flight SHALL discard them; no read_valid after release.

Verification
REQ-040 Release reset, INIT_CLEAR=1, SIZE=256 -> busy high exactly 256 cycles; then reads of addresses 0, 128, 255 return 0.
REQ-041 Write 0xAABBCCDD to addr 5 with be=1111, then 0x11223344 with be=0101 -> read addr 5 returns 0xAA22CC44.
REQ-042 Addr 7 holds 0x1; same cycle write 0x2 and read addr 7 -> RDW_MODE=0 returns 0x1, RDW_MODE=1 returns 0x2.
REQ-043 OUT_REG=1, back-to-back reads addr 1,2,3 -> read_valid high 3 consecutive cycles starting 2 cycles after first read; data in order.
REQ-044 SIZE=200: write addr 210, read addr 210 -> read returns 0, read_valid pulses, addrs 0..199 unchanged.
REQ-045 Assert rst_n mid-CLEAR at counter 100 -> after release busy high a full 256 cycles; requests during busy produce no read_valid and no writes.
